lynx_ps2_keymatrix: RTL and testbench

LYNX_PS2_KEYMATRIX -- requirements
Module: lynx_ps2_keymatrix

---
 rtl/lynx_ps2_keymatrix.sv | 228 ++++++++++++++++++++++
 tb/tb_lynx_ps2_keymatrix.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : lynx_ps2_keymatrix
//  Description : PS/2 keyboard receiver feeding a 10x8 Lynx keyboard matrix.
//                Frames are deserialised, checked for odd parity and stop bit,
//                then decoded (E0/F0 prefixes) into active-low matrix bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lynx_ps2_keymatrix #(
    parameter int TIMEOUT     = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_osd,
    input  logic [1:0] ps2,
    input  logic [3:0] row,
    output logic [7:0] cols,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam int            ROWS    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (preset high: an idle PS/2 bus reads released)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            // Single-stage capture of the raw PS/2 lines
            always_ff @(posedge clock or negedge reset_osd) begin
                if (!reset_osd) begin
                    clk_sync <= '1;
                    dat_sync <= '1;
                end else begin
                    clk_sync[0] <= ps2[0];
                    dat_sync[0] <= ps2[1];
                end
            end
        end else begin : g_sync_chain
            // Multi-stage shift chain for metastability settling
            always_ff @(posedge clock or negedge reset_osd) begin
                if (!reset_osd) begin
                    clk_sync <= '1;
                    dat_sync <= '1;
                end else begin
                    clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2[0]};
                    dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2[1]};
                end
            end
        end
    endgenerate

    logic ps2_clk_s;
    logic ps2_dat_s;
    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          clk_prev;

    logic fall;
    logic timeout_hit;
    logic frame_ok;

    assign fall        = clk_prev & ~ps2_clk_s;
    // The counter reaches TIMEOUT in the same edge that abandons the frame
    assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TO_LAST);
    // Odd parity over data+parity, and a high stop bit
    assign frame_ok    = ps2_dat_s && (^{shift, parity_bit});

    // Frame FSM with edge detect, timeout counter and registered strobes
    always_ff @(posedge clock or negedge reset_osd) begin
        if (!reset_osd) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            clk_prev   <= 1'b1;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            clk_prev   <= ps2_clk_s;

            if (fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!ps2_dat_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                            shift   <= 8'h00;
                        end
                    end
                    DATA: begin
                        shift   <= {ps2_dat_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= ps2_dat_s;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (frame_ok) begin
                            code       <= shift;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder and key matrix
    // ------------------------------------------------------------------
    logic       ext;
    logic       brk;
    logic [7:0] matrix [ROWS];

    logic       key_hit;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       self_test;

    // Lookup of {ext, code} into a Lynx (row, column) position
    always_comb begin
        key_hit = 1'b1;
        key_row = 4'd0;
        key_col = 3'd0;
        case ({ext, code})
            9'h076: begin key_row = 4'd0; key_col = 3'd1; end  // ESC
            9'h016: begin key_row = 4'd0; key_col = 3'd0; end  // 1
            9'h014: begin key_row = 4'd0; key_col = 3'd6; end  // CTRL
            9'h012: begin key_row = 4'd0; key_col = 3'd7; end  // LSHIFT
            9'h059: begin key_row = 4'd0; key_col = 3'd7; end  // RSHIFT
            9'h01E: begin key_row = 4'd1; key_col = 3'd0; end  // 2
            9'h015: begin key_row = 4'd1; key_col = 3'd1; end  // Q
            9'h024: begin key_row = 4'd1; key_col = 3'd2; end  // E
            9'h01B: begin key_row = 4'd2; key_col = 3'd4; end  // S
            9'h01C: begin key_row = 4'd2; key_col = 3'd5; end  // A
            9'h032: begin key_row = 4'd3; key_col = 3'd2; end  // B
            9'h031: begin key_row = 4'd4; key_col = 3'd2; end  // N
            9'h05A: begin key_row = 4'd8; key_col = 3'd3; end  // RETURN
            9'h066: begin key_row = 4'd8; key_col = 3'd6; end  // BACKSPACE
            9'h175: begin key_row = 4'd8; key_col = 3'd2; end  // UP
            9'h172: begin key_row = 4'd8; key_col = 3'd5; end  // DOWN
            9'h029: begin key_row = 4'd9; key_col = 3'd3; end  // SPACE
            9'h16B: begin key_row = 4'd9; key_col = 3'd2; end  // LEFT
            9'h174: begin key_row = 4'd9; key_col = 3'd5; end  // RIGHT
            default: key_hit = 1'b0;
        endcase
    end

    // Keyboard power-on self-test reply releases every key
    assign self_test = !ext && !brk && ((code == 8'hAA) || (code == 8'hFC));

    // Prefix tracking and matrix update on each good byte
    always_ff @(posedge clock or negedge reset_osd) begin
        if (!reset_osd) begin
            ext <= 1'b0;
            brk <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                matrix[r] <= 8'hFF;
            end
        end else if (code_valid) begin
            if (code == 8'hE0) begin
                ext <= 1'b1;
            end else if (code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (self_test) begin
                    for (int r = 0; r < ROWS; r++) begin
                        matrix[r] <= 8'hFF;
                    end
                end else if (key_hit) begin
                    matrix[key_row][key_col] <= brk;
                end
            end
        end
    end

    // Combinational row read; rows beyond the matrix read as released
    assign cols = (row < 4'(ROWS)) ? matrix[row] : 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_lynx_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lynx_ps2_keymatrix
//  Description : Self-checking bench for lynx_ps2_keymatrix. Received-byte
//                and frame-error strobes are matched against a scoreboard
//                queue filled as frames are sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lynx_ps2_keymatrix;

    localparam int TIMEOUT     = 200;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;    // PS/2 half bit period in system clocks

    logic       clock     = 1'b0;
    logic       reset_osd = 1'b0;
    logic [1:0] ps2       = 2'b11;
    logic [3:0] row       = 4'd0;
    logic [7:0] cols;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int w_cnt;
    int t_cnt;
    logic seen;

    typedef struct packed {
        logic       is_err;
        logic [7:0] value;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    always #5 clock = ~clock;

    lynx_ps2_keymatrix #(
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock     (clock),
        .reset_osd (reset_osd),
        .ps2       (ps2),
        .row       (row),
        .cols      (cols),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (code_valid === 1'b1 || frame_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_strobe", {30'd0, code_valid, frame_err}, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("strobe_kind", {30'd0, code_valid, frame_err},
                         sb_e.is_err ? 32'd1 : 32'd2);
                if (!sb_e.is_err) begin
                    check_eq("code", {24'd0, code}, {24'd0, sb_e.value});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        ps2[1] = b;
        tick(HALF);
        ps2[0] = 1'b0;
        tick(HALF);
        ps2[0] = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good_par);
        logic p;
        p = ~^b;
        if (!good_par) p = ~p;
        if (good_par) sb_q.push_back({1'b0, b});
        else          sb_q.push_back({1'b1, 8'h00});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        tick(HALF);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq(tag, sb_q.size(), 32'd0);
        tick(2);
    endtask

    task automatic expect_cols(input string tag, input logic [3:0] r, input logic [7:0] exp);
        row = r;
        #1;
        check_eq(tag, {24'd0, cols}, {24'd0, exp});
    endtask

    initial begin
        // Reset values
        tick(3);
        check_eq("rst_code",       {24'd0, code}, 32'h00);
        check_eq("rst_code_valid", {31'd0, code_valid}, 32'd0);
        check_eq("rst_frame_err",  {31'd0, frame_err}, 32'd0);
        expect_cols("rst_cols_r0", 4'd0, 8'hFF);
        expect_cols("rst_cols_r2", 4'd2, 8'hFF);
        reset_osd = 1'b1;
        tick(5);

        // Make "A" while row switches in the strobe cycle
        row = 4'd0;
        fork
            send_frame(8'h1C, 1'b1);
            begin
                w_cnt = 0;
                while (code_valid !== 1'b1 && w_cnt < 400) begin
                    tick(1);
                    w_cnt++;
                end
                row = 4'd2;
                #1;
                check_eq("same_cycle_preupdate", {24'd0, cols}, 32'hFF);
                tick(1);
                check_eq("a_make", {24'd0, cols}, 32'hDF);
            end
        join
        drain("a_make_drain");

        // Break "A"
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        drain("a_break_drain");
        expect_cols("a_break", 4'd2, 8'hFF);

        // Extended UP make/break, then keypad 8 without E0
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        drain("up_make_drain");
        expect_cols("up_make", 4'd8, 8'hFB);
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        drain("up_break_drain");
        expect_cols("up_break", 4'd8, 8'hFF);
        send_frame(8'h75, 1'b1);
        drain("kp8_drain");
        expect_cols("kp8_no_effect", 4'd8, 8'hFF);

        // Parity error leaves code and matrix untouched
        send_frame(8'h1C, 1'b0);
        drain("parity_drain");
        check_eq("parity_code_kept", {24'd0, code}, 32'h75);
        expect_cols("parity_matrix_kept", 4'd2, 8'hFF);
        send_frame(8'h1C, 1'b1);
        drain("after_parity_drain");
        expect_cols("after_parity_make", 4'd2, 8'hDF);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        drain("after_parity_break_drain");

        // Timeout after start + 4 data bits; latency counted from the
        // system-clock edge that registers the last synchronised fall
        sb_q.push_back({1'b1, 8'h00});
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2[1] = 1'b1;
        tick(HALF);
        ps2[0] = 1'b0;
        t_cnt = 0;
        seen  = 1'b0;
        while (t_cnt < TIMEOUT + 50 && !seen) begin
            tick(1);
            t_cnt++;
            if (t_cnt == HALF) ps2[0] = 1'b1;
            if (frame_err === 1'b1) seen = 1'b1;
        end
        check_eq("timeout_latency", t_cnt, TIMEOUT + SYNC_STAGES + 1);
        tick(1);
        check_eq("timeout_single_pulse", {31'd0, frame_err}, 32'd0);
        drain("timeout_drain");
        send_frame(8'h29, 1'b1);
        drain("space_drain");
        expect_cols("space_after_timeout", 4'd9, 8'hF7);

        // Shared shift bit
        send_frame(8'h12, 1'b1);
        send_frame(8'h59, 1'b1);
        drain("shift_make_drain");
        expect_cols("shift_both", 4'd0, 8'h7F);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h12, 1'b1);
        drain("shift_break_drain");
        expect_cols("shift_shared_release", 4'd0, 8'hFF);

        // Out-of-range rows, then self-test reply releases everything
        expect_cols("row10", 4'd10, 8'hFF);
        expect_cols("row15", 4'd15, 8'hFF);
        send_frame(8'hAA, 1'b1);
        drain("selftest_drain");
        expect_cols("selftest_release", 4'd9, 8'hFF);

        // Reset mid-frame
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        drain("pre_reset_drain");
        expect_cols("pre_reset_up", 4'd8, 8'hFB);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2[1] = 1'b0;
        tick(2);
        ps2[0] = 1'b0;
        reset_osd = 1'b0;
        tick(2);
        check_eq("midrst_code",       {24'd0, code}, 32'h00);
        check_eq("midrst_code_valid", {31'd0, code_valid}, 32'd0);
        check_eq("midrst_frame_err",  {31'd0, frame_err}, 32'd0);
        expect_cols("midrst_cols", 4'd8, 8'hFF);
        ps2 = 2'b11;
        tick(3);
        reset_osd = 1'b1;
        tick(HALF * 4);
        check_eq("post_rst_no_strobe_q", sb_q.size(), 32'd0);
        send_frame(8'h5A, 1'b1);
        drain("return_drain");
        expect_cols("return_make", 4'd8, 8'hF7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
